// File: rtl/bit16_uart_tx_if.sv
// ---------------------------------------------------------------------------
// bit16_uart_tx_if
// Word-level handshake between the data path and the 16-bit UART transmitter.
//   baud_sel     : baud select, latched together with the word
//   bit16_in     : 16-bit word to transmit (high byte goes out first)
//   bit16_in_vld : word valid (master -> slave)
//   bit16_in_rdy : transmitter ready to accept a word (slave -> master)
// ---------------------------------------------------------------------------
interface bit16_uart_tx_if;
    logic [2:0]  baud_sel;
    logic [15:0] bit16_in;
    logic        bit16_in_vld;
    logic        bit16_in_rdy;

    modport master (
        output baud_sel,
        output bit16_in,
        output bit16_in_vld,
        input  bit16_in_rdy
    );

    modport slave (
        input  baud_sel,
        input  bit16_in,
        input  bit16_in_vld,
        output bit16_in_rdy
    );
endinterface

// File: rtl/bit16_uart_tx.sv
// ---------------------------------------------------------------------------
// bit16_uart_tx
// Serialises 16-bit words onto a UART line as two back-to-back 8N1 frames,
// high byte first. Transmit counterpart of the uart_rx + bit82bit16 chain and
// shares its baud divider set and baud_sel encoding.
// Ports:
//   clk     : wr_clk, 50 MHz
//   rst_n   : asynchronous active-low reset
//   bus     : word handshake (baud_sel, bit16_in, bit16_in_vld, bit16_in_rdy)
//   uart_tx : serial line, idle high, driven straight from a flop
//   tx_busy : high from the cycle after acceptance until the low stop bit ends
// ---------------------------------------------------------------------------
module bit16_uart_tx #(
    parameter int unsigned BAUD_9600   = 32'd5208,
    parameter int unsigned BAUD_19200  = 32'd2604,
    parameter int unsigned BAUD_38400  = 32'd1302,
    parameter int unsigned BAUD_57600  = 32'd868,
    parameter int unsigned BAUD_115200 = 32'd434
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bit16_uart_tx_if.slave        bus,
    output logic                  uart_tx,
    output logic                  tx_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Clocks-per-bit lookup; codes 5..7 alias to the fastest rate.
    function automatic logic [12:0] baud_div(input logic [2:0] sel);
        logic [12:0] div;
        case (sel)
            3'd0:    div = 13'(BAUD_9600);
            3'd1:    div = 13'(BAUD_19200);
            3'd2:    div = 13'(BAUD_38400);
            3'd3:    div = 13'(BAUD_57600);
            default: div = 13'(BAUD_115200);
        endcase
        return div;
    endfunction

    state_t      state_q,    state_d;
    logic [12:0] cnt_q,      cnt_d;       // clock count within the current bit
    logic [2:0]  bit_idx_q,  bit_idx_d;   // data bit index within a byte
    logic [7:0]  shift_q,    shift_d;     // byte on the line, bit 0 is next out
    logic [7:0]  low_q,      low_d;       // low byte parked until the high frame ends
    logic [12:0] div_q,      div_d;       // clocks per bit latched at acceptance
    logic        hi_phase_q, hi_phase_d;  // 1 while the high byte frame is on the line
    logic        tx_q,       tx_d;
    logic        busy_q,     busy_d;
    logic        rdy_q,      rdy_d;
    logic        bit_end_s;

    assign uart_tx          = tx_q;
    assign tx_busy          = busy_q;
    assign bus.bit16_in_rdy = rdy_q;

    // Next-state and next-output computation for the framing state machine.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        low_d      = low_q;
        div_d      = div_q;
        hi_phase_d = hi_phase_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        rdy_d      = rdy_q;
        bit_end_s  = (cnt_q == (div_q - 13'd1));

        case (state_q)
            ST_IDLE: begin
                cnt_d     = 13'd0;
                bit_idx_d = 3'd0;
                // rdy_q gates acceptance, so nothing is taken in the first
                // cycle after reset release.
                if (rdy_q && bus.bit16_in_vld) begin
                    state_d    = ST_START;
                    shift_d    = bus.bit16_in[15:8];
                    low_d      = bus.bit16_in[7:0];
                    div_d      = baud_div(bus.baud_sel);
                    hi_phase_d = 1'b1;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    rdy_d      = 1'b0;
                end else begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                    rdy_d  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_d     = 13'd0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d = 13'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_d = 13'd0;
                    if (hi_phase_q) begin
                        // Low byte follows immediately with no idle gap.
                        state_d    = ST_START;
                        shift_d    = low_q;
                        hi_phase_d = 1'b0;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        rdy_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 13'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drives the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 13'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            low_q      <= 8'd0;
            div_q      <= 13'd0;
            hi_phase_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            low_q      <= low_d;
            div_q      <= div_d;
            hi_phase_q <= hi_phase_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            rdy_q      <= rdy_d;
        end
    end

endmodule

// File: doc/bit16_uart_tx.md
Name: bit16_uart_tx

Overview:
- Serialises 16-bit words from the pixel/data path onto a UART TX line as two 8N1 frames.
- Sends the high byte first, then the low byte: the transmit counterpart of the uart_rx + bit82bit16 receive chain.
- Runs in the 50 MHz wr_clk domain and uses the same baud-divider set and baud_sel encoding as the receiver.
- Used for read-back of DDR3 contents and for debug dumps to the host.

Parameters:
- BAUD_9600, 5208, clocks per bit for baud_sel=0
- BAUD_19200, 2604, clocks per bit for baud_sel=1
- BAUD_38400, 1302, clocks per bit for baud_sel=2
- BAUD_57600, 868, clocks per bit for baud_sel=3
- BAUD_115200, 434, clocks per bit for baud_sel=4 and for any baud_sel value 5..7

Ports:
- clk  input  1  system clock (wr_clk, 50 MHz)
- rst_n  input  1  asynchronous active-low reset
- baud_sel  input  3  baud select; sampled only when a word is accepted
- bit16_in  input  16  word to transmit
- bit16_in_vld  input  1  word valid
- bit16_in_rdy  output  1  ready to accept a word
- uart_tx  output  1  serial line; idle high
- tx_busy  output  1  high from the cycle after acceptance until the low byte's stop bit completes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - uart_tx=1, tx_busy=0, state=IDLE, all counters and shift registers cleared.
  - bit16_in_rdy=0 while reset is asserted; it rises to 1 on the first clock edge after release.
- Handshake:
  - A word is accepted on a clock edge where bit16_in_vld & bit16_in_rdy.
  - bit16_in_rdy is registered: 1 only in IDLE, and 0 from the cycle after acceptance.
  - At acceptance the block latches bit16_in and the divider selected by baud_sel (N).
  - bit16_in_vld while not ready is ignored; the word is not queued.
- Frame format:
  - 8N1, LSB first: start(0), d0..d7, stop(1).
  - Every bit lasts exactly N clocks.
  - The bit counter runs 0..N-1 and advances to the next bit on N-1.
- State machine (registered):
  - IDLE → START on acceptance; uart_tx goes 0 in the cycle after acceptance.
  - START → DATA after N clocks.
  - DATA → STOP after 8 bits.
  - STOP after N clocks: if the high byte was just sent, go to START for the low byte [7:0] with no idle gap; otherwise go to IDLE.
- Whole-word timing:
  - A word occupies exactly 20*N clocks on the line (115200: 8680 clocks).
  - In IDLE, uart_tx=1 and bit16_in_rdy=1, so back-to-back words have a minimum gap of 1 clock of idle-high between the low stop bit and the next start bit.
- Mid-word changes: changing baud_sel or bit16_in during a word has no effect.
- Reset mid-frame: the line goes high immediately, the word is discarded, and there is no partial completion.
- uart_tx is driven directly from a flip-flop (glitch-free).

Test Plan:
- 0xA55A at baud_sel=4 → line sequence:
  - 0,1,0,1,0,0,1,0,1,1 (0xA5) then 0,0,1,0,1,1,0,1,0,1 (0x5A).
  - Each bit lasts 434 clocks; total 8680 clocks.
  - tx_busy is high for exactly 8680 clocks.
- baud_sel=0 with word 0x0001 → every bit lasts 5208 clocks. baud_sel=7 → every bit lasts 434 clocks.
- vld held high with words 0x1234 then 0x5678 → both are sent in order. Check:
  - bit16_in_rdy is high for exactly 1 cycle between the two words.
  - There is exactly 1 idle-high clock between them.
  - Decoded bytes are 12,34,56,78.
- vld pulsed with 0xFFFF during a word in flight → ignored, and the line output is unchanged.
- baud_sel changed from 4 to 0 mid-word → the current word completes at 434 clocks per bit; the next word uses 5208.
- rst_n pulsed low during the data bits of the high byte → uart_tx=1 asynchronously and tx_busy=0. After release: bit16_in_rdy=1, and the next word 0x00FF transmits correctly.
